td4_clk_ctrl: RTL and testbench
===============================

Name: td4_clk_ctrl

Overview:
- Clock/step controller for the TD4 CPU. Replaces the free-running divider that currently drives the CPU clock.
- Synchronises and debounces the raw KEY input and classifies each press as short or long.
- Produces the TD4 clock in one of two modes:
  - run mode: free-running divided clock.
  - step mode: one clock pulse per short press.
- Sits between the board KEY/XTAL_IN pins and the td4_logic CLOCK and IN inputs.

Parameters:
- DEB_CYCLES, 270000: cycles the synchronised key must be stable before key_db changes (10 ms at 27 MHz).
- LONG_CYCLES, 27000000: debounced-press duration that counts as a long press (1 s).
- RUN_DIV_LOG2, 22: in run mode, cpu_clk toggles every 2^RUN_DIV_LOG2 cycles.
- STEP_HI, 1350000: cpu_clk high time in cycles for one step pulse (50 ms).

Ports:
- CLK  in  1  system clock (XTAL_IN domain). All logic is on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- KEY  in  1  raw pushbutton, active-low, asynchronous to CLK.
- cpu_clk  out  1  clock to td4_logic CLOCK.
- cpu_rise  out  1  one-cycle strobe, high in the cycle in which cpu_clk goes 0->1.
- run_mode  out  1  1 = run mode, 0 = step mode.
- key_db  out  1  debounced key state, active-high (1 = pressed). Feeds td4 IN[0].

Behaviour:
- Reset (nRST low, asynchronous):
  - cpu_clk=0, cpu_rise=0, run_mode=1, key_db=0.
  - All counters 0; synchroniser flops 1 (released); key FSM in IDLE.
- Sync: 2-flop synchroniser on KEY, then inversion, giving key_s (active-high).
- Debounce:
  - A counter increments while key_s != key_db and clears whenever key_s == key_db.
  - When the counter reaches DEB_CYCLES-1, key_db takes key_s and the counter clears.
  - Latency: key_db changes 2 + DEB_CYCLES cycles after a clean KEY edge.
  - Glitches shorter than DEB_CYCLES are never seen on key_db.
- Key FSM (hold counter saturates at LONG_CYCLES):
  - IDLE: on key_db 0->1, go to PRESS and clear the hold counter.
  - PRESS: hold counter increments each cycle.
    - If key_db falls before the counter reaches LONG_CYCLES: issue a short event (one cycle), go to IDLE.
    - If the counter reaches LONG_CYCLES with key_db still 1: issue a long event (one cycle), go to HELD.
  - HELD: on key_db falling, go to IDLE. No event is issued on this release.
- Long event:
  - Toggles run_mode.
  - Forces cpu_clk=0 and clears the run prescaler and the step timer in the same cycle.
  - cpu_rise is never asserted on that cycle.
- Run mode (run_mode=1):
  - Prescaler counts 0..2^RUN_DIV_LOG2-1 and wraps.
  - At each wrap cpu_clk toggles, giving period 2^(RUN_DIV_LOG2+1).
  - After a mode entry or reset, the first rising edge occurs 2^RUN_DIV_LOG2 cycles later.
  - Short events are ignored for clocking.
- Step mode (run_mode=0):
  - A short event while the step timer is idle starts a pulse: on the next cycle cpu_clk=1 and cpu_rise=1.
  - cpu_clk stays high for exactly STEP_HI cycles, then returns to 0.
  - The timer is then idle and cpu_clk holds 0.
  - A short event during an active pulse is dropped (no queueing).
- cpu_rise: asserted exactly once per cpu_clk 0->1 transition, in either mode.
- Simultaneous long event and run wrap: the long event wins; cpu_clk=0 and no toggle.
- Reset mid-pulse or mid-press: immediately returns to reset state. A key still held at release of reset needs a full debounce and is treated as a new press.
- All outputs are registered.

Decomposition:
- Package td4_pkg:
  - key FSM state enum (IDLE, PRESS, HELD).
  - Default constants for DEB_CYCLES, LONG_CYCLES, RUN_DIV_LOG2, STEP_HI.
- Sub-module key_debounce:
  - Contains the synchroniser and debounce counter.
  - Parameter DEB_CYCLES; ports CLK, nRST, KEY, key_db.
  - Instantiated once inside td4_clk_ctrl.

Test Plan (bench params: DEB_CYCLES=4, LONG_CYCLES=20, RUN_DIV_LOG2=2, STEP_HI=3):
- Reset release, KEY=1 -> run_mode=1; cpu_clk rises at cycle 4 after reset and toggles every 4 cycles; cpu_rise pulses once every 8 cycles.
- KEY low 2 cycles, then high -> key_db stays 0; no state change.
- KEY low 30 cycles -> key_db=1 at cycle 6; long event at 20 cycles of key_db=1; run_mode=0; cpu_clk=0 and stays 0; release produces no step.
- Step mode, KEY low 10 cycles -> on debounced release, cpu_clk=1 for exactly 3 cycles with a single cpu_rise.
- Step mode, second short press completing inside an active pulse -> dropped; exactly one pulse total.
- Long press while in step mode, then nRST low mid-run-pulse -> run_mode=1 after the long event; on reset all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/td4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : td4_pkg                                                          |
// | Purpose  : Shared types and default timing constants for the TD4 clock/step |
// |            controller (key FSM state encoding, debounce/long-press/run/step |
// |            cycle counts for a 27 MHz system clock).                         |
// | Ports    : none (package)                                                   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package td4_pkg;

   // Key press classifier states.
   typedef enum logic [1:0] {
      KEY_IDLE  = 2'd0,
      KEY_PRESS = 2'd1,
      KEY_HELD  = 2'd2
   } key_state_t;

   // Defaults for a 27 MHz XTAL_IN.
   localparam int DEF_DEB_CYCLES   = 270000;    // 10 ms
   localparam int DEF_LONG_CYCLES  = 27000000;  // 1 s
   localparam int DEF_RUN_DIV_LOG2 = 22;        // ~3.2 Hz run clock
   localparam int DEF_STEP_HI      = 1350000;   // 50 ms step pulse

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debounce                                                     |
// | Purpose  : Two-flop synchroniser plus stability-counter debouncer for the   |
// |            active-low board pushbutton. Output is active-high.             |
// | Ports    : CLK    in  system clock                                          |
// |            nRST   in  asynchronous active-low reset                         |
// |            KEY    in  raw pushbutton, active-low, asynchronous              |
// |            key_db out debounced key state, 1 = pressed (registered)         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module key_debounce
   import td4_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
)(
   input  logic CLK,
   input  logic nRST,
   input  logic KEY,
   output logic key_db
);

   localparam int                 c_cnt_w    = $clog2(DEB_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

   logic [1:0]         r_sync;
   logic               w_key_s;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_key_db;

   // Synchroniser flops reset to 1 (button released), so a key already held
   // when reset lifts is seen as a fresh edge and must debounce in full.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], KEY};
      end
   end

   assign w_key_s = ~r_sync[1];

   // The counter only runs while the synchronised key disagrees with the
   // debounced state; any agreement restarts it, which filters glitches.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt    <= '0;
         r_key_db <= 1'b0;
      end else if (w_key_s == r_key_db) begin
         r_cnt    <= '0;
      end else if (r_cnt == c_cnt_last) begin
         r_cnt    <= '0;
         r_key_db <= w_key_s;
      end else begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   assign key_db = r_key_db;

endmodule
`default_nettype wire

// File: rtl/td4_clk_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : td4_clk_ctrl                                                     |
// | Purpose  : Clock/step controller for the TD4 CPU. Debounces KEY, classifies|
// |            presses as short/long, and generates cpu_clk either as a free-  |
// |            running divided clock (run mode) or one pulse per short press    |
// |            (step mode). A long press toggles the mode.                      |
// | Ports    : CLK      in  system clock                                        |
// |            nRST     in  asynchronous active-low reset                       |
// |            KEY      in  raw pushbutton, active-low                          |
// |            cpu_clk  out clock to td4_logic CLOCK                            |
// |            cpu_rise out one-cycle strobe in the cycle cpu_clk goes 0->1     |
// |            run_mode out 1 = run mode, 0 = step mode                         |
// |            key_db   out debounced key, 1 = pressed                          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module td4_clk_ctrl
   import td4_pkg::*;
#(
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int LONG_CYCLES  = DEF_LONG_CYCLES,
   parameter int RUN_DIV_LOG2 = DEF_RUN_DIV_LOG2,
   parameter int STEP_HI      = DEF_STEP_HI
)(
   input  logic CLK,
   input  logic nRST,
   input  logic KEY,
   output logic cpu_clk,
   output logic cpu_rise,
   output logic run_mode,
   output logic key_db
);

   localparam int                  c_hold_w   = $clog2(LONG_CYCLES + 1);
   localparam int                  c_step_w   = $clog2(STEP_HI + 1);
   localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CYCLES);
   localparam logic [c_step_w-1:0] c_step_hi  = c_step_w'(STEP_HI);
   localparam logic [c_step_w-1:0] c_step_one = c_step_w'(1);

   logic                    w_key_db;
   key_state_t              r_state;
   key_state_t              w_state_nxt;
   logic [c_hold_w-1:0]     r_hold;
   logic                    w_short;
   logic                    w_long;
   logic                    r_run_mode;
   logic                    r_cpu_clk;
   logic                    r_cpu_rise;
   logic [RUN_DIV_LOG2-1:0] r_presc;
   logic [c_step_w-1:0]     r_step_cnt;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debounce (
      .CLK    (CLK),
      .nRST   (nRST),
      .KEY    (KEY),
      .key_db (w_key_db)
   );

   // ---------------------------------------------------------------- key FSM
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= KEY_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // IDLE is only ever occupied with key_db low (reset, or after a release),
   // so a high key_db seen in IDLE is the 0->1 edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         KEY_IDLE: begin
            if (w_key_db) w_state_nxt = KEY_PRESS;
         end
         KEY_PRESS: begin
            if (!w_key_db)                 w_state_nxt = KEY_IDLE;
            else if (r_hold == c_hold_max) w_state_nxt = KEY_HELD;
         end
         KEY_HELD: begin
            if (!w_key_db) w_state_nxt = KEY_IDLE;
         end
         default: w_state_nxt = KEY_IDLE;
      endcase
   end

   always_comb begin
      w_short = 1'b0;
      w_long  = 1'b0;
      if (r_state == KEY_PRESS) begin
         w_short = !w_key_db;
         w_long  = w_key_db && (r_hold == c_hold_max);
      end
   end

   // Hold counter is zero on entry to PRESS and saturates at the long limit.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_hold <= '0;
      end else if (r_state != KEY_PRESS) begin
         r_hold <= '0;
      end else if (r_hold != c_hold_max) begin
         r_hold <= r_hold + 1'b1;
      end
   end

   // ------------------------------------------------------- clock generation
   // The long event takes priority over everything, including a run-mode
   // wrap in the same cycle, so a mode change always starts from cpu_clk=0.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_run_mode <= 1'b1;
         r_cpu_clk  <= 1'b0;
         r_cpu_rise <= 1'b0;
         r_presc    <= '0;
         r_step_cnt <= '0;
      end else begin
         r_cpu_rise <= 1'b0;
         if (w_long) begin
            r_run_mode <= ~r_run_mode;
            r_cpu_clk  <= 1'b0;
            r_presc    <= '0;
            r_step_cnt <= '0;
         end else if (r_run_mode) begin
            r_presc <= r_presc + 1'b1;
            if (&r_presc) begin
               r_cpu_clk  <= ~r_cpu_clk;
               r_cpu_rise <= ~r_cpu_clk;
            end
         end else if (r_step_cnt != '0) begin
            // Pulse active: count down the high time; shorts are dropped.
            r_step_cnt <= r_step_cnt - 1'b1;
            if (r_step_cnt == c_step_one) begin
               r_cpu_clk <= 1'b0;
            end
         end else if (w_short) begin
            r_cpu_clk  <= 1'b1;
            r_cpu_rise <= 1'b1;
            r_step_cnt <= c_step_hi;
         end
      end
   end

   assign cpu_clk  = r_cpu_clk;
   assign cpu_rise = r_cpu_rise;
   assign run_mode = r_run_mode;
   assign key_db   = w_key_db;

endmodule
`default_nettype wire

// File: tb/tb_td4_clk_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_td4_clk_ctrl                                                  |
// | Purpose  : Self-checking bench for td4_clk_ctrl. Two DUTs share the inputs:|
// |            A uses a 3-cycle step pulse, B a 12-cycle one so that a second  |
// |            short press can land inside an active pulse. A timestamp-based  |
// |            reference model predicts all outputs every cycle.               |
// | Ports    : none                                                             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_td4_clk_ctrl;

   localparam int DEB    = 4;
   localparam int LONG   = 20;
   localparam int LOG2   = 2;
   localparam int STEP_A = 3;
   localparam int STEP_B = 12;
   localparam int HALF   = 1 << LOG2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic key   = 1'b1;

   logic cpu_clk_a, cpu_rise_a, run_mode_a, key_db_a;
   logic cpu_clk_b, cpu_rise_b, run_mode_b, key_db_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   td4_clk_ctrl #(
      .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .RUN_DIV_LOG2(LOG2), .STEP_HI(STEP_A)
   ) u_dut_a (
      .CLK(clk), .nRST(rst_n), .KEY(key),
      .cpu_clk(cpu_clk_a), .cpu_rise(cpu_rise_a), .run_mode(run_mode_a), .key_db(key_db_a)
   );

   td4_clk_ctrl #(
      .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .RUN_DIV_LOG2(LOG2), .STEP_HI(STEP_B)
   ) u_dut_b (
      .CLK(clk), .nRST(rst_n), .KEY(key),
      .cpu_clk(cpu_clk_b), .cpu_rise(cpu_rise_b), .run_mode(run_mode_b), .key_db(key_db_b)
   );

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: actual=%b expected=%b", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- model
   // Time is the count of rising edges since reset release. Key events and
   // clock outputs are derived from timestamps: when key_db rose, when the
   // current mode was entered, when the current step pulse started.
   int m_e, m_entry, m_run, m_rise_t, m_short_at;
   bit m_db, m_mode, m_pending, m_q0, m_q1;
   int m_p   [2];
   bit m_clk [2];
   bit m_rise[2];

   function automatic int step_hi(input int i);
      return (i == 0) ? STEP_A : STEP_B;
   endfunction

   task automatic model_reset();
      m_e = 0; m_entry = 0; m_run = 0; m_rise_t = -1000; m_short_at = -1;
      m_db = 1'b0; m_mode = 1'b1; m_pending = 1'b0; m_q0 = 1'b1; m_q1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_p[i] = -1000; m_clk[i] = 1'b0; m_rise[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit ks, long_now, short_now;
      int k;
      m_e++;
      // Long press: key_db still high once it has been high LONG+2 edges.
      long_now  = m_pending && (m_e == m_rise_t + LONG + 2);
      if (long_now) m_pending = 1'b0;
      short_now = (m_e == m_short_at);
      // Key seen two edges late, inverted; debounced after DEB disagreeing edges.
      ks = ~m_q0; m_q0 = m_q1; m_q1 = key;
      if (ks != m_db) begin
         m_run++;
         if (m_run == DEB) begin
            m_db = ks; m_run = 0;
            if (ks) begin
               m_rise_t = m_e; m_pending = 1'b1;
            end else if (m_pending) begin
               m_short_at = m_e + 1; m_pending = 1'b0;
            end
         end
      end else begin
         m_run = 0;
      end
      if (long_now) begin
         m_mode = ~m_mode; m_entry = m_e;
         m_p[0] = -1000; m_p[1] = -1000;
      end else if (!m_mode && short_now) begin
         for (int i = 0; i < 2; i++)
            if (m_e > m_p[i] + step_hi(i)) m_p[i] = m_e;
      end
      k = m_e - m_entry;
      for (int i = 0; i < 2; i++) begin
         if (m_mode) begin
            m_clk[i]  = ((k / HALF) % 2) == 1;
            m_rise[i] = (k > 0) && ((k % (2 * HALF)) == HALF);
         end else begin
            m_clk[i]  = (m_e >= m_p[i]) && (m_e < m_p[i] + step_hi(i));
            m_rise[i] = (m_e == m_p[i]);
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // -------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_cpu_clk_a",  cpu_clk_a,  1'b0);
         check("rst_cpu_rise_a", cpu_rise_a, 1'b0);
         check("rst_run_mode_a", run_mode_a, 1'b1);
         check("rst_key_db_a",   key_db_a,   1'b0);
         check("rst_cpu_clk_b",  cpu_clk_b,  1'b0);
         check("rst_run_mode_b", run_mode_b, 1'b1);
      end else begin
         check("key_db_a",   key_db_a,   m_db);
         check("run_mode_a", run_mode_a, m_mode);
         check("cpu_clk_a",  cpu_clk_a,  m_clk[0]);
         check("cpu_rise_a", cpu_rise_a, m_rise[0]);
         check("key_db_b",   key_db_b,   m_db);
         check("run_mode_b", run_mode_b, m_mode);
         check("cpu_clk_b",  cpu_clk_b,  m_clk[1]);
         check("cpu_rise_b", cpu_rise_b, m_rise[1]);
      end
   end

   task automatic wait_clk_high_a(input int budget);
      int n = 0;
      while (cpu_clk_a !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_cpu_clk_a_high", cpu_clk_a, 1'b1);
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int len;
      tick(3);
      #2 rst_n = 1'b1;

      // Run mode after reset: first rise at edge 4, then every 8 edges.
      tick(3);  check("lit_run_e3_clk",  cpu_clk_a,  1'b0);
      tick(1);  check("lit_run_e4_clk",  cpu_clk_a,  1'b1);
                check("lit_run_e4_rise", cpu_rise_a, 1'b1);
      tick(1);  check("lit_run_e5_rise", cpu_rise_a, 1'b0);
      tick(3);  check("lit_run_e8_clk",  cpu_clk_a,  1'b0);
      tick(4);  check("lit_run_e12_rise", cpu_rise_a, 1'b1);

      // Two-cycle glitch never reaches key_db.
      key = 1'b0; tick(2); key = 1'b1;
      tick(20); check("lit_glitch_key_db", key_db_a, 1'b0);
                check("lit_glitch_mode",   run_mode_a, 1'b1);

      // Long press in run mode: key_db at 6, long event effective at 28.
      key = 1'b0;
      tick(5);  check("lit_long_db_e5", key_db_a, 1'b0);
      tick(1);  check("lit_long_db_e6", key_db_a, 1'b1);
      tick(21); check("lit_long_mode_e27", run_mode_a, 1'b1);
      tick(1);  check("lit_long_mode_e28", run_mode_a, 1'b0);
                check("lit_long_clk_e28",  cpu_clk_a,  1'b0);
      tick(2);  key = 1'b1;
      tick(20); check("lit_held_release_clk", cpu_clk_a, 1'b0);

      // Step mode single short press: pulse of exactly 3 cycles.
      key = 1'b0; tick(10); key = 1'b1;
      tick(6);  check("lit_step_r6_clk",  cpu_clk_a,  1'b0);
      tick(1);  check("lit_step_r7_clk",  cpu_clk_a,  1'b1);
                check("lit_step_r7_rise", cpu_rise_a, 1'b1);
      tick(1);  check("lit_step_r8_rise", cpu_rise_a, 1'b0);
      tick(2);  check("lit_step_r10_clk", cpu_clk_a,  1'b0);
                check("lit_step_r10_clk_b", cpu_clk_b, 1'b1);
      tick(20);

      // Second short press lands exactly where B's pulse ends: dropped by B.
      key = 1'b0; tick(10); key = 1'b1;
      tick(6);  key = 1'b0;
      tick(6);  key = 1'b1;
      tick(7);  check("lit_drop_b_clk",  cpu_clk_b,  1'b0);
                check("lit_drop_b_rise", cpu_rise_b, 1'b0);
                check("lit_second_a_rise", cpu_rise_a, 1'b1);
      tick(20);

      // Long press back to run mode, then reset in the middle of a high phase.
      key = 1'b0; tick(30);
      check("lit_back_to_run", run_mode_a, 1'b1);
      key = 1'b1;
      wait_clk_high_a(50);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("lit_async_rst_clk_a",  cpu_clk_a,  1'b0);
      check("lit_async_rst_rise_a", cpu_rise_a, 1'b0);
      check("lit_async_rst_mode_a", run_mode_a, 1'b1);
      check("lit_async_rst_db_a",   key_db_a,   1'b0);
      check("lit_async_rst_clk_b",  cpu_clk_b,  1'b0);

      // Key held through reset release needs a full debounce.
      key = 1'b0;
      tick(3);
      #2 rst_n = 1'b1;
      tick(5);  check("lit_held_rst_db_e5", key_db_a, 1'b0);
      tick(1);  check("lit_held_rst_db_e6", key_db_a, 1'b1);
      tick(10); key = 1'b1;
      tick(20);

      // Random presses: glitches, shorts and longs with random gaps.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       len = $urandom_range(1, 3);
            1:       len = $urandom_range(5, 15);
            default: len = $urandom_range(25, 40);
         endcase
         key = 1'b0; tick(len);
         key = 1'b1; tick($urandom_range(8, 40));
      end

      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
